// File: rtl/ram_bist_master.sv
// ram_bist_master: BIST sequencer for a single-port synchronous RAM.
// On a start pulse it writes an address-derived pattern to every location,
// reads every location back, and reports pass/fail, a saturating error count
// and the first failing address.
//
// Optional feature macro: RAM_BIST_INV_PASS_EN. When it is defined, a second
// write/read pass runs with the pattern inverted. Errors from both passes
// accumulate into the same count.
//
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-high reset
//   start        - begin a test; only looked at in IDLE
//   mem_we       - RAM write enable
//   mem_addr     - RAM address
//   mem_din      - RAM write data
//   mem_dout     - RAM registered read data (one cycle of read latency)
//   busy         - a test is in progress
//   done         - one-cycle pulse at the end of a test
//   pass         - result of the last completed test
//   err_cnt      - mismatch count, saturating at all-ones
//   err_addr     - address of the first mismatch (0 if none)
module ram_bist_master #(
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned DATA_W = 2,
   parameter int unsigned ERR_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] err_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state_q,    state_d;
   logic                mem_we_q,   mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_din_q,  mem_din_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
   logic                pass_q,     pass_d;
   logic [ERR_W-1:0]    err_cnt_q,  err_cnt_d;
   logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
   // Read-compare pipeline stage aligned with the RAM read latency
   logic                rd_vld_q,   rd_vld_d;
   logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
   logic [DATA_W-1:0]   exp_data_q, exp_data_d;

   // XOR mask applied to the base pattern for the current pass
   logic [DATA_W-1:0]   mask_c;

`ifdef RAM_BIST_INV_PASS_EN
   logic                inv_q,      inv_d;
   assign mask_c = {DATA_W{inv_q}};
`else
   assign mask_c = '0;
`endif

   // Base pattern: address truncated or zero-extended to the data width
   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
      return DATA_W'(a);
   endfunction

   // Next-state, output and compare logic
   always_comb begin
      state_d    = state_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      rd_vld_d   = 1'b0;
      exp_addr_d = exp_addr_q;
      exp_data_d = exp_data_q;
`ifdef RAM_BIST_INV_PASS_EN
      inv_d      = inv_q;
`endif

      // Compare the RAM output against the pipelined expectation; the count
      // can never return to zero within a test, so zero marks "no mismatch yet"
      if (rd_vld_q && (mem_dout != exp_data_q)) begin
         if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
         if (err_cnt_q == '0) begin
            err_addr_d = exp_addr_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_WRITE;
               busy_d     = 1'b1;
               pass_d     = 1'b0;
               err_cnt_d  = '0;
               err_addr_d = '0;
               mem_we_d   = 1'b1;
               mem_addr_d = '0;
               mem_din_d  = pat('0);
`ifdef RAM_BIST_INV_PASS_EN
               inv_d      = 1'b0;
`endif
            end
         end

         S_WRITE: begin
            if (mem_addr_q == LAST_ADDR) begin
               state_d    = S_READ;
               mem_we_d   = 1'b0;
               mem_addr_d = '0;
               mem_din_d  = '0;
            end else begin
               mem_addr_d = mem_addr_q + ADDR_W'(1);
               mem_din_d  = pat(mem_addr_q + ADDR_W'(1)) ^ mask_c;
            end
         end

         S_READ: begin
            rd_vld_d   = 1'b1;
            exp_addr_d = mem_addr_q;
            exp_data_d = pat(mem_addr_q) ^ mask_c;
            if (mem_addr_q == LAST_ADDR) begin
               state_d    = S_DRAIN;
               mem_addr_d = '0;
            end else begin
               mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
         end

         S_DRAIN: begin
`ifdef RAM_BIST_INV_PASS_EN
            if (!inv_q) begin
               inv_d      = 1'b1;
               state_d    = S_WRITE;
               mem_we_d   = 1'b1;
               mem_addr_d = '0;
               mem_din_d  = pat('0) ^ {DATA_W{1'b1}};
            end else begin
`endif
               // The last compare lands on this edge, so use its updated count
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (err_cnt_d == '0);
`ifdef RAM_BIST_INV_PASS_EN
            end
`endif
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         rd_vld_q   <= 1'b0;
         exp_addr_q <= '0;
         exp_data_q <= '0;
`ifdef RAM_BIST_INV_PASS_EN
         inv_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         rd_vld_q   <= rd_vld_d;
         exp_addr_q <= exp_addr_d;
         exp_data_q <= exp_data_d;
`ifdef RAM_BIST_INV_PASS_EN
         inv_q      <= inv_d;
`endif
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_cnt  = err_cnt_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ram_bist_master.sv
// Testbench for ram_bist_master: two DUTs (ERR_W=4 with a configurable read
// fault, ERR_W=2 with every read inverted) run against behavioural RAMs.
// Expected results come from a pass/address-level model and are checked by
// a monitor as each done pulse appears.
module tb_ram_bist_master;

   localparam int ADDR_W = 2;
   localparam int DATA_W = 2;
   localparam int ERR_W  = 4;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef RAM_BIST_INV_PASS_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif
   localparam int LAT = NPASS * (2 * DEPTH + 1);

   typedef struct {
      int err_cnt;
      int err_addr;
      int pass;
      int chk_gap;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   logic              mem_we, busy, done, pass;
   logic [ADDR_W-1:0] mem_addr, err_addr;
   logic [DATA_W-1:0] mem_din, mem_dout;
   logic [ERR_W-1:0]  err_cnt;

   logic              mem_we2, busy2, done2, pass2;
   logic [ADDR_W-1:0] mem_addr2, err_addr2;
   logic [DATA_W-1:0] mem_din2, mem_dout2;
   logic [1:0]        err_cnt2;

   int errors = 0;
   int checks = 0;
   int fault  = 0;   // 0 healthy, 1 bit0 stuck-at-0, 2 every read inverted
   int cyc    = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ram_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_addr(err_addr)
   );

   ram_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start),
      .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_dout(mem_dout2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .err_addr(err_addr2)
   );

   function automatic logic [DATA_W-1:0] apply_fault(input logic [DATA_W-1:0] w, input int flt);
      logic [DATA_W-1:0] one;
      one = 1;
      case (flt)
         1:       return w & ~one;
         2:       return ~w;
         default: return w;
      endcase
   endfunction

   // Behavioural single-port RAMs with one cycle of registered read latency
   logic [DATA_W-1:0] ram  [DEPTH];
   logic [DATA_W-1:0] ram2 [DEPTH];
   logic [DATA_W-1:0] ram_q, ram2_q;
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        ram_q <= ram[mem_addr];
      if (mem_we2) ram2[mem_addr2] <= mem_din2;
      else         ram2_q <= ram2[mem_addr2];
   end
   always_comb mem_dout  = apply_fault(ram_q, fault);
   always_comb mem_dout2 = apply_fault(ram2_q, 2);

   // Reference: every pass writes pat(a) (inverted on the second pass) and
   // reads it back through the fault; tally mismatches
   function automatic exp_t model(input int flt, input int errw, input int gap);
      exp_t e;
      int errs;
      int first;
      logic [DATA_W-1:0] w;
      errs  = 0;
      first = 0;
      for (int p = 0; p < NPASS; p++) begin
         for (int a = 0; a < DEPTH; a++) begin
            w = DATA_W'(a);
            if (p == 1) w = ~w;
            if (apply_fault(w, flt) != w) begin
               if (errs == 0) first = a;
               errs++;
            end
         end
      end
      e.err_cnt  = (errs > (1 << errw) - 1) ? (1 << errw) - 1 : errs;
      e.err_addr = first;
      e.pass     = (errs == 0) ? 1 : 0;
      e.chk_gap  = gap;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor for the main DUT: write stream, done timing and results
   int   rise_cyc = 0;
   int   last_done_cyc = -100;
   int   wr_k = 0;
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      logic [DATA_W-1:0] wexp;
      if (busy && !busy_prev) begin
         rise_cyc = cyc;
         wr_k = 0;
         if (sb.size() > 0 && sb[0].chk_gap != 0)
            check("idle_gap", rise_cyc - last_done_cyc, 2);
      end
      if (mem_we) begin
         wexp = DATA_W'(wr_k % DEPTH);
         if (wr_k / DEPTH != 0) wexp = ~wexp;
         check("wr_addr", int'(mem_addr), wr_k % DEPTH);
         check("wr_data", int'(mem_din), int'(wexp));
         wr_k++;
      end
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("err_cnt", int'(err_cnt), e.err_cnt);
            check("err_addr", int'(err_addr), e.err_addr);
            check("pass", int'(pass), e.pass);
            check("done_latency", cyc - rise_cyc, LAT);
            check("busy_at_done", int'(busy), 0);
         end
         last_done_cyc = cyc;
      end
      busy_prev = busy;
   end

   // Monitor for the narrow-counter DUT: every test must saturate
   always @(negedge clk) begin
      exp_t e2;
      if (done2) begin
         e2 = model(2, 2, 0);
         check("sat_err_cnt", int'(err_cnt2), e2.err_cnt);
         check("sat_err_addr", int'(err_addr2), e2.err_addr);
         check("sat_pass", int'(pass2), e2.pass);
      end
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done) return;
      end
      check("done_timeout", 0, 1);
   endtask

   initial begin
      #2;
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_mem_din", int'(mem_din), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass), 0);
      check("rst_err_cnt", int'(err_cnt), 0);
      check("rst_err_addr", int'(err_addr), 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      // Healthy RAM
      fault = 0;
      sb.push_back(model(0, ERR_W, 0));
      pulse_start();
      wait_done(200);

      // Bit0 stuck-at-0
      fault = 1;
      sb.push_back(model(1, ERR_W, 0));
      pulse_start();
      wait_done(200);

      // Extra start pulses while busy are ignored
      fault = 0;
      sb.push_back(model(0, ERR_W, 0));
      pulse_start();
      repeat (2) @(negedge clk);
      pulse_start();
      repeat (2) @(negedge clk);
      pulse_start();
      wait_done(200);
      repeat (3) @(negedge clk);

      // Reset in the middle of the READ phase (cycle after edge t0+7)
      fault = 1;
      pulse_start();
      repeat (7) @(negedge clk);
      check("pre_rst_busy", int'(busy), 1);
      check("pre_rst_err_cnt", int'(err_cnt), 1);
      #1 rst = 1'b1;
      #1;
      check("midrst_mem_we", int'(mem_we), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_err_cnt", int'(err_cnt), 0);
      check("midrst_mem_addr", int'(mem_addr), 0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      fault = 0;
      sb.push_back(model(0, ERR_W, 0));
      pulse_start();
      wait_done(200);

      // Start held high: back-to-back tests, pass tracks each result
      fault = 1;
      sb.push_back(model(1, ERR_W, 0));
      @(negedge clk) start = 1'b1;
      wait_done(200);
      fault = 0;
      sb.push_back(model(0, ERR_W, 1));
      wait_done(200);
      fault = 2;
      sb.push_back(model(2, ERR_W, 1));
      wait_done(200);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // Randomized faults, gaps and spurious start pulses
      for (int n = 0; n < 10; n++) begin
         fault = int'($urandom_range(0, 2));
         sb.push_back(model(fault, ERR_W, 0));
         pulse_start();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, LAT - 4)) @(negedge clk);
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
         end
         wait_done(200);
         repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
